mult_share_arb: RTL

Round-robin arbiter that time-shares one combinational signed multiplier (in0/in1 -> out0, 2W-bit product) among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The arbiter grants one requester per cycle and drives the shared multiplier's inputs.
- It registers the product with the winner's ID into a one-entry result stage drained by a valid/ready consumer.
- It sits between requester datapaths and the single multiplier instance, which is instantiated outside this block.

---
 rtl/mult_share_arb.sv | 118 +++++++++++
 1 files changed

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one external signed multiplier among NREQ requesters.
// Latency: a request accepted at edge t shows its product in the result stage in cycle t+1.
// Backpressure: while the result stage is full and res_ready is low, no requester is granted.
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mult_in0,
  output logic [W-1:0]      mult_in1,
  input  logic [2*W-1:0]    mult_out0,
  output logic              res_valid,
  output logic [2*W-1:0]    res_prod,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic [CNTW-1:0]   op_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic [2*W-1:0]    res_prod_q, res_prod_d;
  logic [CNTW-1:0]   op_count_q, op_count_d;

  logic              can_issue;
  logic              gnt_vld;
  logic [IDW-1:0]    gnt_id;
  logic [NREQ-1:0]   gnt_oh;
  logic              consume;
  int                idx;

  // Round-robin search from ptr upward with wrap; gated off while in reset
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    idx       = 0;
    can_issue = (state_q == EMPTY) || res_ready;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && can_issue && rst_n && req_valid[idx]) begin
        gnt_vld     = 1'b1;
        gnt_id      = IDW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  // Steer the winner's operands to the shared multiplier, zero when idle
  always_comb begin
    mult_in0 = '0;
    mult_in1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        mult_in0 = req_a[i*W +: W];
        mult_in1 = req_b[i*W +: W];
      end
    end
  end

  // Result-stage FSM, pointer advance and consume counter
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    res_id_d   = res_id_q;
    res_prod_d = res_prod_q;
    op_count_d = op_count_q;
    consume    = (state_q == FULL) && res_ready;
    if (consume) begin
      op_count_d = op_count_q + 1'b1;
    end
    if (gnt_vld) begin
      state_d    = FULL;
      res_prod_d = mult_out0;
      res_id_d   = gnt_id;
      ptr_d      = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (consume) begin
      state_d = EMPTY;
    end
  end

  // State registers; reset discards any held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      res_id_q   <= '0;
      res_prod_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      res_id_q   <= res_id_d;
      res_prod_q <= res_prod_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready = gnt_oh;
  assign res_valid = (state_q == FULL);
  assign res_prod  = res_prod_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule
